// File: rtl/chain_score_pipe.sv
// Pipelined anchor-pair chaining score: min(dr, dq, w) - gap_cost(|dr - dq|), saturating.
// Optional band/distance rejection is built when CHAIN_SCORE_BAND_CHECK_EN is defined.
module chain_score_pipe #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int FRAC = 8,
  parameter int TAGW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   ri,
  input  logic [DW-1:0]   rj,
  input  logic [DW-1:0]   qi,
  input  logic [DW-1:0]   qj,
  input  logic [DW-1:0]   w,
  input  logic [AW-1:0]   avg_span,
  input  logic [DW-1:0]   max_dist,
  input  logic [DW-1:0]   bw,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_score,
  output logic            out_ok,
  output logic [TAGW-1:0] out_tag
);
  localparam int PW  = DW + 2 + AW;
  localparam int LW  = PW - FRAC;
  localparam int LGW = $clog2(DW + 2);
  localparam logic [LW:0] CMAX = {{(LW - DW + 2){1'b0}}, {(DW-1){1'b1}}};

  function automatic logic [LGW-1:0] msb_idx(input logic [DW+1:0] x);
    msb_idx = '0;
    for (int k = 0; k < DW + 2; k++)
      if (x[k]) msb_idx = LGW'(k);
  endfunction

  // vld_pipe[0] is the input register, vld_pipe[4] the output register
  logic [4:0] vld_pipe;
  logic       stall;

  logic [DW-1:0]   s0_ri, s0_rj, s0_qi, s0_qj, s0_w, s0_md, s0_bw;
  logic [AW-1:0]   s0_avg;
  logic [TAGW-1:0] s0_tag;

  logic signed [DW:0] s1_dr, s1_dq;
  logic [DW-1:0]      s1_w, s1_md, s1_bw;
  logic [AW-1:0]      s1_avg;
  logic [TAGW-1:0]    s1_tag;

  logic [DW+1:0]      s2_dd;
  logic signed [DW:0] s2_mn;
  logic               s2_ok;
  logic [DW-1:0]      s2_w;
  logic [AW-1:0]      s2_avg;
  logic [TAGW-1:0]    s2_tag;

  logic signed [DW+1:0] s3_a;
  logic [LW-1:0]        s3_lin;
  logic [LGW-1:0]       s3_lg;
  logic                 s3_dz, s3_ok;
  logic [TAGW-1:0]      s3_tag;

  assign stall     = vld_pipe[4] && !out_ready;
  assign in_ready  = !stall && !reset;
  assign out_valid = vld_pipe[4];

  // S1: signed deltas
  logic signed [DW:0] dr_n, dq_n;
  assign dr_n = $signed({1'b0, s0_ri}) - $signed({1'b0, s0_rj});
  assign dq_n = $signed({1'b0, s0_qi}) - $signed({1'b0, s0_qj});

  // S2: gap, min delta, legality
  logic signed [DW+1:0] diff;
  logic [DW+1:0]        dd_n;
  logic signed [DW:0]   mn_n;
  logic                 ok_n;
  assign diff = $signed({s1_dr[DW], s1_dr}) - $signed({s1_dq[DW], s1_dq});
  assign dd_n = diff[DW+1] ? DW'(0) - diff : diff;
  assign mn_n = (s1_dr < s1_dq) ? s1_dr : s1_dq;
`ifdef CHAIN_SCORE_BAND_CHECK_EN
  assign ok_n = (s1_dr > 0) && (s1_dq > 0)
             && ($signed({s1_dr[DW], s1_dr}) <= $signed({2'b00, s1_md}))
             && ($signed({s1_dq[DW], s1_dq}) <= $signed({2'b00, s1_md}))
             && (dd_n <= {2'b00, s1_bw});
`else
  logic unused_band;
  assign unused_band = ^{s1_md, s1_bw};
  assign ok_n = (s1_dr > 0) && (s1_dq > 0);
`endif

  // S3: capped match length, linear and log gap terms
  logic signed [DW+1:0] a_n;
  logic [PW-1:0]        prod;
  logic [LW-1:0]        lin_n;
  logic [LGW-1:0]       lg_n;
  assign a_n   = ($signed({s2_mn[DW], s2_mn}) < $signed({2'b00, s2_w})) ?
                 {s2_mn[DW], s2_mn} : {2'b00, s2_w};
  assign prod  = PW'(s2_dd) * PW'(s2_avg);
  assign lin_n = LW'(prod >> FRAC);
  assign lg_n  = msb_idx(s2_dd) >> 1;

  // S4: saturate cost, clamp score, force minimum for rejected pairs
  logic [LW:0]          cost_sum;
  logic [DW-2:0]        cost_c;
  logic signed [DW+1:0] sc, sc_c;
  logic [DW-1:0]        score_n;
  assign cost_sum = s3_dz ? '0 : {1'b0, s3_lin} + (LW+1)'(s3_lg);
  assign cost_c   = (cost_sum > CMAX) ? '1 : cost_sum[DW-2:0];
  assign sc       = s3_a - $signed({3'b000, cost_c});
  assign sc_c     = (sc > $signed({3'b000, {(DW-1){1'b1}}})) ? $signed({3'b000, {(DW-1){1'b1}}}) :
                    (sc < $signed({3'b111, {(DW-1){1'b0}}})) ? $signed({3'b111, {(DW-1){1'b0}}}) : sc;
  assign score_n  = s3_ok ? DW'(sc_c) : {1'b1, {(DW-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s0_ri <= '0; s0_rj <= '0; s0_qi <= '0; s0_qj <= '0;
      s0_w <= '0; s0_md <= '0; s0_bw <= '0; s0_avg <= '0; s0_tag <= '0;
      s1_dr <= '0; s1_dq <= '0; s1_w <= '0; s1_md <= '0; s1_bw <= '0;
      s1_avg <= '0; s1_tag <= '0;
      s2_dd <= '0; s2_mn <= '0; s2_ok <= 1'b0; s2_w <= '0; s2_avg <= '0; s2_tag <= '0;
      s3_a <= '0; s3_lin <= '0; s3_lg <= '0; s3_dz <= 1'b0; s3_ok <= 1'b0; s3_tag <= '0;
      out_score <= '0; out_ok <= 1'b0; out_tag <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[3:0], in_valid};
      s0_ri <= ri; s0_rj <= rj; s0_qi <= qi; s0_qj <= qj;
      s0_w <= w; s0_md <= max_dist; s0_bw <= bw; s0_avg <= avg_span; s0_tag <= in_tag;
      s1_dr <= dr_n; s1_dq <= dq_n; s1_w <= s0_w; s1_md <= s0_md; s1_bw <= s0_bw;
      s1_avg <= s0_avg; s1_tag <= s0_tag;
      s2_dd <= dd_n; s2_mn <= mn_n; s2_ok <= ok_n; s2_w <= s1_w; s2_avg <= s1_avg;
      s2_tag <= s1_tag;
      s3_a <= a_n; s3_lin <= lin_n; s3_lg <= lg_n; s3_dz <= (s2_dd == '0);
      s3_ok <= s2_ok; s3_tag <= s2_tag;
      out_score <= score_n; out_ok <= s3_ok; out_tag <= s3_tag;
    end
  end
endmodule

// File: tb/tb_chain_score_pipe.sv
// Directed bench for chain_score_pipe: table of single pairs, streaming with backpressure,
// and reset while pairs are in flight.
module tb_chain_score_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_ok;
  logic [31:0] ri, rj, qi, qj, w, max_dist, bw, out_score;
  logic [15:0] avg_span, in_tag, out_tag;

  chain_score_pipe #(.DW(32), .AW(16), .FRAC(8), .TAGW(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ri(ri), .rj(rj), .qi(qi), .qj(qj), .w(w), .avg_span(avg_span),
    .max_dist(max_dist), .bw(bw), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_score(out_score), .out_ok(out_ok), .out_tag(out_tag));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ri, rj, qi, qj, w;
    logic [15:0] avg;
    logic [31:0] md, bw;
    logic [15:0] tag;
    logic [31:0] score;
    logic        ok;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[11];
  localparam logic [31:0] BIG = 32'hFFFF_FFFF;
  localparam logic [31:0] NEG = 32'h8000_0000;

  function automatic vec_t mk(input logic [31:0] a, b, c, d, ww, input logic [15:0] av,
                              input logic [31:0] md, bb, input logic [15:0] tg,
                              input logic [31:0] sc, input logic k);
    vec_t v;
    v.ri = a; v.rj = b; v.qi = c; v.qj = d; v.w = ww; v.avg = av;
    v.md = md; v.bw = bb; v.tag = tg; v.score = sc; v.ok = k;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    ri = v.ri; rj = v.rj; qi = v.qi; qj = v.qj; w = v.w; avg_span = v.avg;
    max_dist = v.md; bw = v.bw; in_tag = v.tag;
  endtask

  // Present one pair, measure edges until out_valid, compare the result.
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    set_in(v);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_score"}, out_score, v.score);
    chk({nm, "_ok"}, out_ok, v.ok);
    chk({nm, "_tag"}, out_tag, v.tag);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, oidx, scnt;
    logic held;
    logic [31:0] p_score;
    logic [15:0] p_tag;
    logic p_ok;
    logic acc;

    tbl[0]  = mk(1000, 900, 500, 420, 15, 38, BIG, BIG, 16'h0001, 32'd11, 1'b1);
    tbl[1]  = mk(150, 100, 250, 200, 15, 38, BIG, BIG, 16'h0002, 32'd15, 1'b1);
    tbl[2]  = mk(150, 100, 250, 200, 80, 38, BIG, BIG, 16'h0003, 32'd50, 1'b1);
    tbl[3]  = mk(1000, 900, 300, 300, 15, 38, BIG, BIG, 16'h0004, NEG, 1'b0);
`ifdef CHAIN_SCORE_BAND_CHECK_EN
    tbl[4]  = mk(5000, 1000, 7000, 1000, 15, 38, 5000, BIG, 16'h0005, NEG, 1'b0);
    tbl[9]  = mk(1000, 900, 500, 420, 15, 38, BIG, 10, 16'h000A, NEG, 1'b0);
`else
    tbl[4]  = mk(5000, 1000, 7000, 1000, 15, 38, 5000, BIG, 16'h0005, 32'hFFFF_FEE2, 1'b1);
    tbl[9]  = mk(1000, 900, 500, 420, 15, 38, BIG, 10, 16'h000A, 32'd11, 1'b1);
`endif
    tbl[5]  = mk(32'h7FFF_FFFF, 0, 10, 0, 10, 16'hFFFF, BIG, BIG, 16'h0006, 32'h8000_000B, 1'b1);
    tbl[6]  = mk(32'h7FFF_FFFF, 0, 1, 0, 10, 16'hFFFF, BIG, BIG, 16'h0007, 32'h8000_0002, 1'b1);
    tbl[7]  = mk(100, 200, 300, 100, 15, 38, BIG, BIG, 16'h0008, NEG, 1'b0);
    tbl[8]  = mk(200, 100, 200, 100, 0, 38, BIG, BIG, 16'h0009, 32'd0, 1'b1);
    tbl[10] = mk(1000, 0, 3000, 0, 500, 16'h0180, BIG, BIG, 16'h000B, 32'hFFFF_F637, 1'b1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_score", out_score, 0);
    chk("rst_out_ok", out_ok, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Streaming: 10 back-to-back pairs, out_ready low during cycles 6..8
    idx = 0; oidx = 0; scnt = 0; held = 1'b0;
    p_score = '0; p_tag = '0; p_ok = 1'b0;
    for (int c = 0; c < 60 && oidx < 10; c++) begin
      out_ready = !(c >= 6 && c < 9);
      if (idx < 10) begin
        ri = 500 + idx; rj = 480; qi = 700 + idx; qj = 680; w = 1000;
        avg_span = 38; max_dist = BIG; bw = BIG; in_tag = 16'h00A0 + 16'(idx);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      chk("stream_in_ready", in_ready, !(out_valid && !out_ready));
      if (held) begin
        chk("held_score", out_score, p_score);
        chk("held_ok", out_ok, p_ok);
        chk("held_tag", out_tag, p_tag);
      end
      held = out_valid && !out_ready;
      if (held) scnt++;
      p_score = out_score; p_ok = out_ok; p_tag = out_tag;
      if (out_valid && out_ready) begin
        chk("stream_score", out_score, 32'd20 + 32'(oidx));
        chk("stream_tag", out_tag, 16'h00A0 + 16'(oidx));
        oidx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", oidx, 10);
    chk("stall_cycles", scnt, 3);
    for (int c = 0; c < 3; c++) begin
      chk("stream_no_dup", out_valid, 0);
      @(posedge clk); #1;
    end

    // Reset with three pairs in flight
    for (int i = 0; i < 3; i++) begin
      set_in(tbl[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("midrst_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    run_vec(tbl[10], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
